// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the multi-port register bank and the CPU core around it.
// Holds default geometry, sweep FSM state encoding and port-slicing helpers.
package regbank_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 16;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } rb_state_e;

  // Bit offset of port idx inside a flattened bus of w-bit fields.
  function automatic int unsigned port_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regbank_mp_if.sv
// Decode/writeback-facing bus of the register bank: read ports, two write ports, scoreboard set.
// Every field is level-sampled on the rising edge; there is no valid/ready handshake per access.
interface regbank_mp_if
  import regbank_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned NR    = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NR*AW-1:0]    rd_addr;
  logic [NR*WIDTH-1:0] rd_data;
  logic [NR-1:0]       rd_pending;
  logic                hold;
  logic                clear;
  logic                wr0_en;
  logic [AW-1:0]       wr0_addr;
  logic [WIDTH-1:0]    wr0_data;
  logic                wr1_en;
  logic [AW-1:0]       wr1_addr;
  logic [WIDTH-1:0]    wr1_data;
  logic                sb_set_en;
  logic [AW-1:0]       sb_set_addr;
  logic                ready;
  rb_state_e           dbg_state;

  modport master (
    output rd_addr, hold, clear,
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    output sb_set_en, sb_set_addr,
    input  rd_data, rd_pending, ready, dbg_state
  );

  modport slave (
    input  rd_addr, hold, clear,
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    input  sb_set_en, sb_set_addr,
    output rd_data, rd_pending, ready, dbg_state
  );

endinterface

// File: rtl/regbank_bypass.sv
// Per-read-port forwarding mux: wr1 beats wr0 beats the array, and reg0 always reads zero.
module regbank_bypass
  import regbank_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AW    = 4
) (
  input  logic [AW-1:0]    rd_addr_i,
  input  logic [WIDTH-1:0] arr_data_i,
  input  logic             wr0_en_i,
  input  logic [AW-1:0]    wr0_addr_i,
  input  logic [WIDTH-1:0] wr0_data_i,
  input  logic             wr1_en_i,
  input  logic [AW-1:0]    wr1_addr_i,
  input  logic [WIDTH-1:0] wr1_data_i,
  output logic [WIDTH-1:0] rd_data_o
);

  always_comb begin
    rd_data_o = arr_data_i;
    if (wr0_en_i && (wr0_addr_i == rd_addr_i)) rd_data_o = wr0_data_i;
    if (wr1_en_i && (wr1_addr_i == rd_addr_i)) rd_data_o = wr1_data_i;
    if (rd_addr_i == '0)                       rd_data_o = '0;
  end

endmodule

// File: rtl/regbank_mp.sv
// Multi-port register bank with registered, write-bypassed reads and a pending-write scoreboard.
// After reset a sweep zeroes one register per cycle before the bank reports ready.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned NR    = 2
) (
  input  logic        clk,
  input  logic        reset,
  regbank_mp_if.slave bus
);

  localparam int unsigned   AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rb_state_e        state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             run;
  logic             wr0_ok, wr1_ok, sb_ok;

  assign run    = (state_q == ST_READY);
  assign wr0_ok = run && bus.wr0_en && (bus.wr0_addr != '0);
  assign wr1_ok = run && bus.wr1_en && (bus.wr1_addr != '0);
  assign sb_ok  = run && bus.sb_set_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_READY;
      end
      ST_READY: begin
        state_d = ST_READY;
      end
    endcase
  end

  // Set is applied last so a newly issued producer outlives a retiring one.
  always_comb begin
    pend_d = pend_q;
    if (wr0_ok) pend_d[bus.wr0_addr] = 1'b0;
    if (wr1_ok) pend_d[bus.wr1_addr] = 1'b0;
    if (sb_ok)  pend_d[bus.sb_set_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Array has no reset; the sweep provides the known contents instead.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (wr0_ok) mem_q[bus.wr0_addr] <= bus.wr0_data;
      if (wr1_ok) mem_q[bus.wr1_addr] <= bus.wr1_data;
    end
  end

  logic [NR*WIDTH-1:0] rd_data_w;
  logic [NR-1:0]       rd_pend_w;

  for (genvar i = 0; i < NR; i++) begin : g_rd
    localparam int unsigned ALSB = port_lsb(i, AW);
    localparam int unsigned DLSB = port_lsb(i, WIDTH);

    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] byp;
    logic [WIDTH-1:0] data_q;
    logic             pend_rd_q;

    assign addr = bus.rd_addr[ALSB +: AW];

    regbank_bypass #(
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_byp (
      .rd_addr_i  (addr),
      .arr_data_i (mem_q[addr]),
      .wr0_en_i   (wr0_ok),
      .wr0_addr_i (bus.wr0_addr),
      .wr0_data_i (bus.wr0_data),
      .wr1_en_i   (wr1_ok),
      .wr1_addr_i (bus.wr1_addr),
      .wr1_data_i (bus.wr1_data),
      .rd_data_o  (byp)
    );

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q    <= '0;
        pend_rd_q <= 1'b0;
      end else if (!run || bus.clear) begin
        data_q    <= '0;
        pend_rd_q <= 1'b0;
      end else if (!bus.hold) begin
        data_q    <= byp;
        pend_rd_q <= pend_d[addr];
      end
    end

    assign rd_data_w[DLSB +: WIDTH] = data_q;
    assign rd_pend_w[i]             = pend_rd_q;
  end

  assign bus.rd_data    = rd_data_w;
  assign bus.rd_pending = rd_pend_w;
  assign bus.ready      = run;
  assign bus.dbg_state  = state_q;

endmodule
